sha256_round_engine_param: RTL and testbench

- Parametrised successor to the single-round-per-cycle SHA-256 compression counter.
- Accepts one 512-bit message block (16 words) and expands the message schedule internally.
- Executes UNROLL rounds per cycle, applies the feed-forward add, and supports multi-block chaining from its own digest register.
- Sits between the padding/block-feeder logic and the digest consumer; presents a ready/start/done handshake.

---
 rtl/sha256_round_engine_param.sv | 160 ++++++++++++++++
 tb/tb_sha256_round_engine_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_engine_param.sv
// SHA-256 compression engine: UNROLL rounds per clock over a 16-word sliding
// message schedule, with feed-forward add and chaining from its own digest.
module sha256_round_engine_param #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         first_block,
    input  logic [511:0] M_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] H_out
);
    localparam int         RUN_CYCLES = 64 / UNROLL;
    localparam logic [5:0] LAST_CNT   = 6'(RUN_CYCLES - 1);

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
            $error("sha256_round_engine_param: UNROLL must be 1, 2, 4 or 8");
        end
    endgenerate

    // Element 0 sits in the MSBs: a/H0 for hashes, word 0 for message blocks.
    typedef logic [0:7][31:0]  hash_t;
    typedef logic [0:15][31:0] block_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_t;

    localparam hash_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // The window always holds W[t0..t0+15]; extend it by UNROLL words and slide.
    function automatic block_t next_window(input block_t w);
        logic [0:15+UNROLL][31:0] ext;
        // NOTE: blocking '=' inside functions and always_comb is intended: each
        // statement must see the value produced by the one before it.
        ext = {w, {UNROLL{32'h0}}};
        for (int j = 0; j < UNROLL; j++) begin
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        end
        return ext[UNROLL +: 16];
    endfunction

    function automatic hash_t run_rounds(input hash_t s, input block_t w, input logic [5:0] cnt);
        hash_t       r;
        logic [31:0] t1;
        logic [31:0] t2;
        r = s;
        for (int u = 0; u < UNROLL; u++) begin
            t1 = r[7] + bsig1(r[4]) + ((r[4] & r[5]) ^ (~r[4] & r[6]))
               + K[6'(int'(cnt) * UNROLL + u)] + w[u];
            t2 = bsig0(r[0]) + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
            r  = {t1 + t2, r[0], r[1], r[2], r[3] + t1, r[4], r[5], r[6]};
        end
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    hash_t      work_q, work_d;
    hash_t      chain_q, chain_d;
    hash_t      hout_q, hout_d;
    block_t     win_q, win_d;
    logic       done_q, done_d;

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no
        // path leaves one unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        chain_d = chain_q;
        hout_d  = hout_q;
        win_d   = win_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    win_d   = M_in;
                    chain_d = first_block ? IV : hout_q;
                    work_d  = first_block ? IV : hout_q;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d = run_rounds(work_q, win_q, cnt_q);
                win_d  = next_window(win_q);
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) state_d = S_FINAL;
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) hout_d[i] = chain_q[i] + work_q[i];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            chain_q <= '0;
            hout_q  <= '0;
            // NOTE: the schedule window is flops, not RAM, so it can and does
            // take a reset value along with the rest of the state.
            win_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            chain_q <= chain_d;
            hout_q  <= hout_d;
            win_q   <= win_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_RUN) || (state_q == S_FINAL);
    assign done  = done_q;
    assign H_out = hout_q;

endmodule

// File: tb/tb_sha256_round_engine_param.sv
// Bench for sha256_round_engine_param: four instances (UNROLL 1/2/4/8) checked
// against known digests and an array-based SHA-256 compression model.
module tb_sha256_round_engine_param;
    localparam int N = 4;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct packed {
        logic [511:0] m;
        logic         first;
        logic         has_exp;
        logic [255:0] exp;
    } vec_t;

    vec_t vt [4];

    logic         clk = 1'b0;
    logic         rst_v   [N];
    logic         start_v [N];
    logic         first_v [N];
    logic [511:0] m_v     [N];
    logic         ready_v [N];
    logic         busy_v  [N];
    logic         done_v  [N];
    logic [255:0] h_v     [N];
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        sha256_round_engine_param #(.UNROLL(1 << gi)) dut (
            .clk        (clk),
            .reset      (rst_v[gi]),
            .start      (start_v[gi]),
            .first_block(first_v[gi]),
            .M_in       (m_v[gi]),
            .ready      (ready_v[gi]),
            .busy       (busy_v[gi]),
            .done       (done_v[gi]),
            .H_out      (h_v[gi])
        );
    end

    task automatic check(input string name, input int idx, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL u%0d %s: got %h expected %h", 1 << idx, name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-entry schedule, then 64 rounds, then add.
    function automatic logic [255:0] model(input logic [255:0] hin, input logic [511:0] m);
        logic [31:0]  w [64];
        logic [31:0]  s [8];
        logic [31:0]  t1, t2, x0, x1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32 * i -: 32];
        for (int i = 16; i < 64; i++) begin
            x0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            x1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = x1 + w[i-7] + x0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) s[i] = hin[255 - 32 * i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
            t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int j = 7; j > 0; j--) s[j] = s[j-1];
            s[4] = s[4] + t1;
            s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = hin[255 - 32 * i -: 32] + s[i];
        return r;
    endfunction

    // Called at posedge+1 with the engine idle; returns just after the acceptance edge.
    task automatic start_block(input int idx, input logic [511:0] m, input logic first);
        start_v[idx] = 1'b1;
        first_v[idx] = first;
        m_v[idx]     = m;
        @(posedge clk); #1;
        start_v[idx] = 1'b0;
        first_v[idx] = 1'($urandom);
        m_v[idx]     = {16{$urandom}};
    endtask

    task automatic wait_done(input int idx, input string tag, output logic [255:0] dig);
        int rc     = 64 >> idx;
        int lat    = 0;
        int n      = 0;
        bit run_ok = 1'b1;
        while (lat == 0 && n < 200) begin
            if (ready_v[idx] || !busy_v[idx]) run_ok = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done_v[idx]) lat = n;
        end
        check({tag, " latency"}, idx, 256'(lat), 256'(rc + 1));
        check({tag, " ready0 busy1 in run"}, idx, 256'(run_ok), 256'(1));
        check({tag, " ready in done cycle"}, idx, 256'(ready_v[idx]), 256'(1));
        dig = h_v[idx];
    endtask

    task automatic idle_gap(input int idx, input string tag);
        @(posedge clk); #1;
        check({tag, " done single pulse"}, idx, 256'(done_v[idx]), 256'(0));
    endtask

    task automatic run_unit(input int idx);
        int           rc = 64 >> idx;
        int           extra;
        logic [255:0] mh = '0;
        logic [255:0] exp;
        logic [255:0] dig;
        logic [511:0] m;
        logic         first;
        bit           got_done;

        // Table vectors; a first=0 entry starts in the previous entry's done cycle.
        for (int v = 0; v < 4; v++) begin
            if (v > 0 && vt[v].first) idle_gap(idx, "table");
            exp = model(vt[v].first ? IV : mh, vt[v].m);
            mh  = exp;
            start_block(idx, vt[v].m, vt[v].first);
            wait_done(idx, $sformatf("vec%0d", v), dig);
            check($sformatf("vec%0d model digest", v), idx, dig, exp);
            if (vt[v].has_exp) check($sformatf("vec%0d known digest", v), idx, dig, vt[v].exp);
        end

        // Random blocks, random chaining, random back-to-back vs gap.
        for (int r = 0; r < 4; r++) begin
            if ($urandom_range(0, 1) == 1) idle_gap(idx, "rand");
            for (int i = 0; i < 16; i++) m[511 - 32 * i -: 32] = $urandom;
            first = 1'($urandom_range(0, 1));
            exp   = model(first ? IV : mh, m);
            mh    = exp;
            start_block(idx, m, first);
            wait_done(idx, $sformatf("rand%0d", r), dig);
            check($sformatf("rand%0d digest", r), idx, dig, exp);
        end
        idle_gap(idx, "rand");

        // start held high with garbage M_in during a run must not re-accept.
        extra        = 0;
        start_v[idx] = 1'b1;
        first_v[idx] = 1'b1;
        m_v[idx]     = ABC;
        @(posedge clk); #1;
        for (int n = 1; n <= rc + 1; n++) begin
            m_v[idx]     = '1;
            first_v[idx] = 1'($urandom);
            @(posedge clk); #1;
            if (n <= rc && done_v[idx]) extra++;
        end
        got_done     = done_v[idx];
        start_v[idx] = 1'b0;
        check("busy-start done on time", idx, 256'(got_done), 256'(1));
        check("busy-start digest", idx, h_v[idx], ABC_D);
        repeat (rc + 4) begin
            @(posedge clk); #1;
            if (done_v[idx]) extra++;
        end
        check("busy-start extra done", idx, 256'(extra), 256'(0));

        // Asynchronous reset mid-cycle around round 30 abandons the block.
        start_block(idx, ABC, 1'b1);
        repeat (30 >> idx) @(posedge clk);
        #3 rst_v[idx] = 1'b1;
        #1;
        check("async reset ready", idx, 256'(ready_v[idx]), 256'(1));
        check("async reset busy", idx, 256'(busy_v[idx]), 256'(0));
        check("async reset done", idx, 256'(done_v[idx]), 256'(0));
        check("async reset H_out", idx, h_v[idx], 256'(0));
        @(posedge clk); #1;
        rst_v[idx] = 1'b0;
        extra = 0;
        repeat (rc + 4) begin
            @(posedge clk); #1;
            if (done_v[idx]) extra++;
        end
        check("abandoned block done", idx, 256'(extra), 256'(0));

        // first_block=0 straight after reset chains from an all-zero H_out.
        start_block(idx, EMPTY, 1'b0);
        wait_done(idx, "zero-chain", dig);
        check("zero-chain digest", idx, dig, model(256'(0), EMPTY));
        idle_gap(idx, "zero-chain");
        start_block(idx, ABC, 1'b1);
        wait_done(idx, "post-reset abc", dig);
        check("post-reset abc digest", idx, dig, ABC_D);
        idle_gap(idx, "post-reset abc");
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rst_v[i]   = 1'b1;
            start_v[i] = 1'b0;
            first_v[i] = 1'b0;
            m_v[i]     = '0;
        end
        vt[0] = '{m: ABC,   first: 1'b1, has_exp: 1'b1, exp: ABC_D};
        vt[1] = '{m: EMPTY, first: 1'b1, has_exp: 1'b1, exp: EMPTY_D};
        vt[2] = '{m: B1,    first: 1'b1, has_exp: 1'b0, exp: '0};
        vt[3] = '{m: B2,    first: 1'b0, has_exp: 1'b1, exp: TWO_D};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) rst_v[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("reset ready", i, 256'(ready_v[i]), 256'(1));
            check("reset busy", i, 256'(busy_v[i]), 256'(0));
            check("reset done", i, 256'(done_v[i]), 256'(0));
            check("reset H_out", i, h_v[i], 256'(0));
        end

        for (int u = 0; u < N; u++) run_unit(u);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
